// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch front end.
// Owns the PC and drives the instruction-memory address. Each fetched word is
// registered into the IF/ID pipeline register. Stalls freeze the front end.
// Redirects load a new PC and squash IF/ID into a bubble.
// Two free-running counters track delivered instructions and inserted bubbles.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [63:0] id_pc_plus4,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  // Architectural state
  logic [63:0] pc_q,           pc_d;
  logic        id_valid_q,     id_valid_d;
  logic [31:0] id_instr_q,     id_instr_d;
  logic [63:0] id_pc_q,        id_pc_d;
  logic [31:0] fetch_count_q,  fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Word-aligned branch target; the low two bits never reach the PC.
  logic [63:0] target_pc;
  assign target_pc = {redirect_pc[63:2], 2'b00};

  // Sequential increment of the PC, modulo 2^64.
  logic [63:0] pc_plus4;
  assign pc_plus4 = pc_q + 64'd4;

  // Next-state selection: redirect beats stall, stall beats a normal fetch.
  always_comb begin
    pc_d           = pc_q;
    id_valid_d     = id_valid_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (redirect) begin
      // Squash whatever was being fetched and restart at the target.
      pc_d           = target_pc;
      id_valid_d     = 1'b0;
      id_instr_d     = 32'h0;
      id_pc_d        = 64'h0;
      bubble_count_d = bubble_count_q + 32'd1;
    end else if (!stall) begin
      // Normal advance: capture the word at the current PC.
      pc_d           = pc_plus4;
      id_valid_d     = 1'b1;
      id_instr_d     = imem_instr;
      id_pc_d        = pc_q;
      fetch_count_d  = fetch_count_q + 32'd1;
    end
  end

  // PC register with asynchronous reset to the boot vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register; reset presents a bubble to decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= 64'h0;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q  <= 32'h0;
      bubble_count_q <= 32'h0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // Outputs come straight from registers; the link value is derived from id_pc.
  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc_q + 64'd4;
  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for the pipelined LEGv8 datapath. Owns the 64-bit PC, drives the instruction-memory address, and registers the fetched word into an IF/ID pipeline register that feeds the decode/control stage. Supports hazard stalls and branch redirects with bubble insertion. Keeps fetch/bubble performance counters for bench and debug use.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  from hazard unit; hold PC and the IF/ID register.
- redirect  input  1  taken branch resolved downstream (B, BL, CBZ, B.cond, BR); load redirect_pc and squash IF/ID.
- redirect_pc  input  64  branch target; bits [1:0] ignored (forced to 0).
- imem_addr  output  64  current PC, to instructmem address.
- imem_instr  input  32  instruction word from instructmem, combinational from imem_addr.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- id_instr  output  32  IF/ID instruction word.
- id_pc  output  64  PC of id_instr.
- id_pc_plus4  output  64  id_pc + 4 (BL link value).
- fetch_count  output  32  instructions delivered into IF/ID.
- bubble_count  output  32  cycles in which IF/ID was loaded with a bubble.

## Operation
- State: pc (64), IF/ID {valid, instr, pc} , two 32-bit counters.
- imem_addr = pc, no combinational path from any input to imem_addr.
- Per rising edge, priority order:
  - redirect=1: pc <= {redirect_pc[63:2], 2'b00}; id_valid <= 0; id_instr <= 0; id_pc <= 0; bubble_count += 1. Redirect overrides stall.
  - else stall=1: pc, id_valid, id_instr, id_pc all hold; no counter changes.
  - else: pc <= pc + 4; id_instr <= imem_instr; id_pc <= pc; id_valid <= 1; fetch_count += 1.
- id_pc_plus4 = id_pc + 4, combinational from the register; for a bubble it reads 4.
- Arithmetic: pc + 4 and id_pc + 4 are modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 = 0). Counters are modulo 2^32, wrapping to 0, no saturation.
- Only one redirect per cycle. The fetch stage does not know the branch type; the upstream branch logic selects PC+offset vs Reg[Rd] before driving redirect_pc.

## Timing
- Reset values, asserted asynchronously while reset=1: pc=RESET_PC (imem_addr=RESET_PC), id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, fetch_count=0, bubble_count=0.
- First edge after reset deasserts with stall=0, redirect=0: IF/ID receives the word at RESET_PC, and imem_addr becomes RESET_PC+4.
- Fetch-to-decode latency: 1 cycle. The word at imem_addr in cycle N is on id_instr in cycle N+1.
- Redirect penalty: the edge on which redirect=1 is sampled produces exactly 1 bubble. The target instruction appears on id_instr one edge later, if not stalled.
- Stall is level-sensitive. N consecutive stall cycles freeze outputs for N edges.
- Reset asserted mid-stream: all state clears within the same cycle, without waiting for clk. Any in-flight redirect or stall is discarded.
- Inputs are sampled only at rising edges. stall and redirect must be glitch-free around the edge; no other handshake is required.

## Test plan
- Reset then run: 3 edges with stall=0, imem holding 0xAAAA0000/0xAAAA0001/0xAAAA0002 at 0/4/8 -> id_instr sequence 0xAAAA0000, 0xAAAA0001, 0xAAAA0002; id_pc 0, 4, 8; id_pc_plus4 4, 8, 12; imem_addr 12; fetch_count=3.
- Stall: with pc=8, hold stall=1 for 2 edges -> imem_addr stays 8, id_instr/id_pc unchanged, counters unchanged. On release, the next edge loads the word at 8 and imem_addr becomes 12.
- Redirect: redirect=1, redirect_pc=0x100 with pc=12 -> next edge id_valid=0, id_instr=0, imem_addr=0x100, bubble_count=1. The following edge gives id_pc=0x100, id_valid=1.
- Redirect + stall same edge with redirect_pc=0x203 -> redirect wins: imem_addr=0x200, bubble inserted, bubble_count increments, fetch_count unchanged.
- Wrap: force a redirect to 0xFFFF_FFFF_FFFF_FFFC, then 1 free edge -> id_pc=0xFFFF_FFFF_FFFF_FFFC, id_pc_plus4=0, imem_addr=0.
- Async reset mid-run: assert reset between edges while id_valid=1 and pc=0x40 -> before the next edge, imem_addr=RESET_PC, id_valid=0, both counters 0.
